// File: rtl/car_park_pkg.sv
// Shared definitions for the car park entry/exit gate controllers.
// Holds the FSM state encoding, the default gate code and the display bus layout.
package car_park_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT_CODE = 4'd1,
        OPEN      = 4'd2,
        LOCKED    = 4'd3
    } state_t;

    localparam logic [3:0] DEFAULT_CODE = 4'b1101;

    // Display bus layout: {occupancy[7:0], tries[3:0], state[3:0]}
    localparam int DISP_STATE_LSB = 0;
    localparam int DISP_TRIES_LSB = 4;
    localparam int DISP_OCC_LSB   = 8;

endpackage

// File: rtl/car_park_exit_occupancy_counter.sv
// 8-bit saturating up/down lot occupancy counter.
// Simultaneous inc and dec cancel; full is registered alongside the count.
module occupancy_counter #(
    parameter int CAPACITY = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] count_o,
    output logic       full_o
);

    localparam logic [7:0] CAP = 8'(CAPACITY);

    logic [7:0] count_q, count_d;
    logic       full_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != CAP)
            count_d = count_q + 8'd1;
        else if (dec_i && !inc_i && count_q != 8'd0)
            count_d = count_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 8'd0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CAP);
        end
    end

    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/car_park_exit.sv
// Exit-side barrier controller: validates the exit code, opens the gate until the
// car clears or a timeout, limits retries with a lockout, and tracks occupancy.
module car_park_exit
    import car_park_pkg::*;
#(
    parameter int         CAPACITY    = 15,
    parameter logic [3:0] EXIT_CODE   = DEFAULT_CODE,
    parameter int         MAX_TRIES   = 3,
    parameter int         GATE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        car_in,
    input  logic        sensor_exit,
    input  logic        sensor_clear,
    input  logic        code_valid,
    input  logic [3:0]  exit_code,
    output logic        gate_open,
    output logic        success,
    output logic        failure,
    output logic        busy,
    output logic        locked,
    output logic        full,
    output logic [7:0]  occupancy,
    output logic [15:0] display
);

    localparam int TW = $clog2(GATE_CYCLES);

    state_t        state_q;
    logic [3:0]    tries_q;
    logic [TW-1:0] timer_q;
    logic          gate_open_q, success_q, failure_q;
    logic          dec;

    assign dec = (state_q == OPEN) && sensor_clear;

    occupancy_counter #(.CAPACITY(CAPACITY)) u_occ (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (car_in),
        .dec_i   (dec),
        .count_o (occupancy),
        .full_o  (full)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tries_q     <= 4'd0;
            timer_q     <= '0;
            gate_open_q <= 1'b0;
            success_q   <= 1'b0;
            failure_q   <= 1'b0;
        end else begin
            success_q <= 1'b0;
            failure_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && sensor_exit && occupancy != 8'd0) begin
                        state_q <= WAIT_CODE;
                        tries_q <= 4'd0;
                    end
                end
                WAIT_CODE: begin
                    // A code strobe is always evaluated, even as the car backs away.
                    if (code_valid) begin
                        if (exit_code == EXIT_CODE) begin
                            success_q   <= 1'b1;
                            gate_open_q <= 1'b1;
                            timer_q     <= TW'(GATE_CYCLES - 1);
                            state_q     <= OPEN;
                        end else begin
                            failure_q <= 1'b1;
                            tries_q   <= tries_q + 4'd1;
                            if (tries_q + 4'd1 == 4'(MAX_TRIES))
                                state_q <= LOCKED;
                        end
                    end else if (!sensor_exit || !enable) begin
                        state_q <= IDLE;
                        tries_q <= 4'd0;
                    end
                end
                OPEN: begin
                    // enable is deliberately ignored: the barrier never drops on a car.
                    if (sensor_clear) begin
                        gate_open_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (timer_q == '0) begin
                        failure_q   <= 1'b1;
                        gate_open_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                LOCKED: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        tries_q <= 4'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gate_open = gate_open_q;
    assign success   = success_q;
    assign failure   = failure_q;
    assign busy      = (state_q != IDLE);
    assign locked    = (state_q == LOCKED);

    always_comb begin
        display = 16'd0;
        display[DISP_OCC_LSB   +: 8] = occupancy;
        display[DISP_TRIES_LSB +: 4] = tries_q;
        display[DISP_STATE_LSB +: 4] = state_q;
    end

endmodule

// File: tb/tb_car_park_exit.sv
// Directed bench for car_park_exit with default parameters (CAPACITY 15, code 1101,
// MAX_TRIES 3, GATE_CYCLES 16). Inputs change and outputs are sampled 1ns after posedge.
module tb_car_park_exit;

    logic        clk = 1'b0;
    logic        reset_n, enable, car_in, sensor_exit, sensor_clear, code_valid;
    logic [3:0]  exit_code;
    logic        gate_open, success, failure, busy, locked, full;
    logic [7:0]  occupancy;
    logic [15:0] display;

    int vectors = 0;
    int miscompares = 0;

    car_park_exit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .car_in       (car_in),
        .sensor_exit  (sensor_exit),
        .sensor_clear (sensor_clear),
        .code_valid   (code_valid),
        .exit_code    (exit_code),
        .gate_open    (gate_open),
        .success      (success),
        .failure      (failure),
        .busy         (busy),
        .locked       (locked),
        .full         (full),
        .occupancy    (occupancy),
        .display      (display)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {gate_open, success, failure, busy, locked}
    function automatic logic [4:0] flags();
        return {gate_open, success, failure, busy, locked};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; car_in = 1'b0; sensor_exit = 1'b0;
        sensor_clear = 1'b0; code_valid = 1'b0; exit_code = 4'd0;
        step(); step();
        vectors++;
        if ({flags(), full, occupancy, display} !== 30'd0) begin
            miscompares++;
            $display("FAIL reset: flags=%b full=%b occ=%0d disp=%h want all 0", flags(), full, occupancy, display);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_exit();
        car_in = 1'b1; step(); step(); step(); car_in = 1'b0;
        vectors++;
        if (occupancy !== 8'd3) begin
            miscompares++; $display("FAIL basic_occ3: occ=%0d want 3", occupancy);
        end
        sensor_exit = 1'b1; step();
        vectors++;
        if (display !== 16'h0301 || flags() !== 5'b00010) begin
            miscompares++; $display("FAIL basic_wait: disp=%h flags=%b want 0301 00010", display, flags());
        end
        code_valid = 1'b1; exit_code = 4'b1101; step(); code_valid = 1'b0;
        vectors++;
        if (flags() !== 5'b11010 || display[3:0] !== 4'd2) begin
            miscompares++; $display("FAIL basic_success: flags=%b st=%0d want 11010 2", flags(), display[3:0]);
        end
        step();
        vectors++;
        if (flags() !== 5'b10010) begin
            miscompares++; $display("FAIL basic_pulse_once: flags=%b want 10010", flags());
        end
        sensor_clear = 1'b1; step(); sensor_clear = 1'b0; sensor_exit = 1'b0;
        vectors++;
        if (occupancy !== 8'd2 || flags() !== 5'b00000 || display !== 16'h0200) begin
            miscompares++; $display("FAIL basic_clear: occ=%0d flags=%b disp=%h want 2 00000 0200", occupancy, flags(), display);
        end
        step();
    endtask

    task automatic test_lockout();
        logic [3:0] bad [3];
        bad[0] = 4'b0000; bad[1] = 4'b1111; bad[2] = 4'b1110;
        sensor_exit = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            code_valid = 1'b1; exit_code = bad[i]; step();
            vectors++;
            if (failure !== 1'b1 || display[7:4] !== 4'(i + 1) || locked !== (i == 2)) begin
                miscompares++;
                $display("FAIL lock_try%0d: fail=%b tries=%0d locked=%b want 1 %0d %b", i, failure, display[7:4], locked, i + 1, i == 2);
            end
        end
        exit_code = 4'b1101; step(); code_valid = 1'b0;
        vectors++;
        if (flags() !== 5'b00011 || display[3:0] !== 4'd3) begin
            miscompares++; $display("FAIL lock_ignore: flags=%b st=%0d want 00011 3", flags(), display[3:0]);
        end
        enable = 1'b0; sensor_exit = 1'b0; step(); enable = 1'b1;
        vectors++;
        if (flags() !== 5'b00000 || display !== 16'h0200) begin
            miscompares++; $display("FAIL lock_release: flags=%b disp=%h want 00000 0200", flags(), display);
        end
        step();
    endtask

    task automatic test_timeout();
        int high = 0;
        sensor_exit = 1'b1; step();
        code_valid = 1'b1; exit_code = 4'b1101; step(); code_valid = 1'b0; sensor_exit = 1'b0;
        if (gate_open === 1'b1) high++;
        for (int i = 0; i < 15; i++) begin
            step();
            if (gate_open === 1'b1 && failure === 1'b0) high++;
        end
        vectors++;
        if (high !== 16) begin
            miscompares++; $display("FAIL timeout_open_cycles: got %0d want 16", high);
        end
        step();
        vectors++;
        if (flags() !== 5'b00100 || occupancy !== 8'd2) begin
            miscompares++; $display("FAIL timeout_fail: flags=%b occ=%0d want 00100 2", flags(), occupancy);
        end
        step();
        vectors++;
        if (failure !== 1'b0) begin
            miscompares++; $display("FAIL timeout_pulse_once: fail=%b want 0", failure);
        end
    endtask

    task automatic test_full();
        car_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 11) begin
                vectors++;
                if (occupancy !== 8'd14 || full !== 1'b0) begin
                    miscompares++; $display("FAIL full_14: occ=%0d full=%b want 14 0", occupancy, full);
                end
            end
        end
        car_in = 1'b0;
        vectors++;
        if (occupancy !== 8'd15 || full !== 1'b1 || display[15:8] !== 8'd15) begin
            miscompares++; $display("FAIL full_sat: occ=%0d full=%b want 15 1", occupancy, full);
        end
        sensor_exit = 1'b1; step();
        code_valid = 1'b1; exit_code = 4'b1101; step(); code_valid = 1'b0; sensor_exit = 1'b0;
        sensor_clear = 1'b1; car_in = 1'b1; step(); sensor_clear = 1'b0; car_in = 1'b0;
        vectors++;
        if (occupancy !== 8'd15 || gate_open !== 1'b0 || full !== 1'b1) begin
            miscompares++; $display("FAIL full_inc_dec: occ=%0d gate=%b full=%b want 15 0 1", occupancy, gate_open, full);
        end
        sensor_exit = 1'b1; step();
        code_valid = 1'b1; step(); code_valid = 1'b0; sensor_exit = 1'b0;
        sensor_clear = 1'b1; step(); sensor_clear = 1'b0;
        vectors++;
        if (occupancy !== 8'd14 || full !== 1'b0) begin
            miscompares++; $display("FAIL full_dec: occ=%0d full=%b want 14 0", occupancy, full);
        end
        step();
    endtask

    task automatic test_empty_and_reset();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        sensor_exit = 1'b1; step(); step();
        vectors++;
        if (busy !== 1'b0 || display !== 16'h0000) begin
            miscompares++; $display("FAIL empty_ignore: busy=%b disp=%h want 0 0000", busy, display);
        end
        car_in = 1'b1; step(); car_in = 1'b0;
        step();
        code_valid = 1'b1; exit_code = 4'b1101; step(); code_valid = 1'b0;
        vectors++;
        if (flags() !== 5'b11010) begin
            miscompares++; $display("FAIL mid_open_setup: flags=%b want 11010", flags());
        end
        step();
        reset_n = 1'b0; step(); reset_n = 1'b1; sensor_exit = 1'b0;
        vectors++;
        if ({flags(), full, occupancy, display} !== 30'd0) begin
            miscompares++;
            $display("FAIL mid_open_reset: flags=%b full=%b occ=%0d disp=%h want all 0", flags(), full, occupancy, display);
        end
        step();
    endtask

    task automatic test_abort();
        car_in = 1'b1; step(); step(); car_in = 1'b0;
        sensor_exit = 1'b1; step();
        code_valid = 1'b1; exit_code = 4'b0110; step(); code_valid = 1'b0;
        vectors++;
        if (display !== 16'h0211 || failure !== 1'b1) begin
            miscompares++; $display("FAIL abort_wrong: disp=%h fail=%b want 0211 1", display, failure);
        end
        sensor_exit = 1'b0; step();
        vectors++;
        if (display !== 16'h0200 || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_idle: disp=%h busy=%b want 0200 0", display, busy);
        end
        sensor_exit = 1'b1; step();
        sensor_exit = 1'b0; code_valid = 1'b1; exit_code = 4'b1101; step(); code_valid = 1'b0;
        vectors++;
        if (flags() !== 5'b11010 || display[3:0] !== 4'd2) begin
            miscompares++; $display("FAIL abort_same_cycle: flags=%b st=%0d want 11010 2", flags(), display[3:0]);
        end
        sensor_clear = 1'b1; step(); sensor_clear = 1'b0;
        vectors++;
        if (occupancy !== 8'd1 || flags() !== 5'b00000) begin
            miscompares++; $display("FAIL abort_clear: occ=%0d flags=%b want 1 00000", occupancy, flags());
        end
    endtask

    initial begin
        test_reset();
        test_basic_exit();
        test_lockout();
        test_timeout();
        test_full();
        test_empty_and_reset();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
